// File: rtl/asynchronous_up_counter_4bit_if.sv
// ---------------------------------------------------------------------------
// asynchronous_up_counter_4bit_if
//
// Bundle of the ripple counter's observable outputs.
//
// Signals (WIDTH = number of counter stages):
//   Q        [WIDTH-1:0]  settled count, unsigned binary, Q[0] = LSB
//   tc                    terminal count, high while Q is all ones
//   wrapped               sticky flag, set when the count rolls over to zero
//
// Modports:
//   master  - the counter, drives all three signals
//   slave   - any consumer of the count
// ---------------------------------------------------------------------------
interface asynchronous_up_counter_4bit_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             wrapped;

    modport master (
        output Q,
        output tc,
        output wrapped
    );

    modport slave (
        input Q,
        input tc,
        input wrapped
    );

endinterface : asynchronous_up_counter_4bit_if

// File: rtl/asynchronous_up_counter_4bit.sv
// ---------------------------------------------------------------------------
// asynchronous_up_counter_4bit
//
// Ripple binary up-counter. Each stage is a toggle flip-flop: stage 0 is
// clocked by clk, every later stage is clocked by the falling edge of the
// stage below it. Bit i of the count is therefore clk divided by 2^(i+1).
// The count is only meaningful once the ripple has settled (up to WIDTH
// flop delays after the clk rising edge).
//
// Parameters:
//   WIDTH    number of stages, legal range 2..16
//
// Ports:
//   clk      counter clock; stage 0 toggles on its rising edge
//   reset    asynchronous active-low clear of every stage and of the
//            wrap flag; 1 = run
//   cnt      master side of asynchronous_up_counter_4bit_if
//              cnt.Q        current count
//              cnt.tc       AND of all count bits (may glitch during ripple)
//              cnt.wrapped  sticky, set on the falling edge of the MSB
// ---------------------------------------------------------------------------
module asynchronous_up_counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    asynchronous_up_counter_4bit_if.master        cnt
);

    // Collected stage outputs. Each bit is driven by exactly one stage flop
    // through a continuous assignment, so every flop keeps its own clock.
    logic [WIDTH-1:0] q_s;
    logic             wrapped_r;

    // -----------------------------------------------------------------------
    // Stage 0: the only flop that sees the system clock.
    // -----------------------------------------------------------------------
    logic stage0_r;

    // Toggle stage 0 on every rising clk edge, clear asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage0_r <= 1'b0;
        end else begin
            stage0_r <= ~stage0_r;
        end
    end

    assign q_s[0] = stage0_r;

    // -----------------------------------------------------------------------
    // Stages 1..WIDTH-1: each is clocked by the 1->0 transition of the
    // previous bit. A falling lower bit is exactly a carry into this bit,
    // which is what makes the chain count up rather than down.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi = gi + 1) begin : g_stage
            logic stage_r;

            // Toggle on the carry out of the lower stage, clear asynchronously.
            always_ff @(negedge q_s[gi-1] or negedge reset) begin
                if (!reset) begin
                    stage_r <= 1'b0;
                end else begin
                    stage_r <= ~stage_r;
                end
            end

            assign q_s[gi] = stage_r;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Wrap detection: the MSB only falls when the whole counter rolls over
    // from all-ones to zero, so its falling edge is the wrap event. When
    // reset pulls a set MSB low the reset branch wins and the flag stays 0.
    // -----------------------------------------------------------------------

    // Sticky wrap flag, cleared only by reset.
    always_ff @(negedge q_s[WIDTH-1] or negedge reset) begin
        if (!reset) begin
            wrapped_r <= 1'b0;
        end else begin
            wrapped_r <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Q and wrapped come straight from flops; tc is decoded from
    // the count and is only valid once the ripple has settled.
    // -----------------------------------------------------------------------
    assign cnt.Q       = q_s;
    assign cnt.tc      = &q_s;
    assign cnt.wrapped = wrapped_r;

endmodule : asynchronous_up_counter_4bit

// File: tb/tb_asynchronous_up_counter_4bit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_asynchronous_up_counter_4bit
//
// Drives a 20 ns clock into the ripple counter, applies directed and random
// reset / counting sequences, and compares the settled outputs against a
// reference built from the counting rules (edges since reset modulo 16,
// wrap seen since reset).
// ---------------------------------------------------------------------------
module tb_asynchronous_up_counter_4bit;

    localparam int WIDTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    asynchronous_up_counter_4bit_if #(.WIDTH(WIDTH)) cnt_if ();

    asynchronous_up_counter_4bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .cnt   (cnt_if)
    );

    // 20 ns period, rising edges at 10, 30, 50, ...
    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: rising edges counted since the last reset release.
    int edges_seen  = 0;
    bit wrap_seen   = 1'b0;

    // Divider measurement.
    longint last_rise [WIDTH];
    longint prev_rise [WIDTH];
    longint high_time [WIDTH];
    logic [WIDTH-1:0] prev_q;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the reference.
    task automatic check_all(input string tag);
        int cnt_exp;
        cnt_exp = edges_seen % MODV;
        check_value({tag, ".Q"},       32'(cnt_if.Q),       32'(cnt_exp));
        check_value({tag, ".tc"},      32'(cnt_if.tc),      32'(cnt_exp == MODV - 1));
        check_value({tag, ".wrapped"}, 32'(cnt_if.wrapped), 32'(wrap_seen));
    endtask

    // One rising edge of clk, then check 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        edges_seen++;
        if (edges_seen >= MODV) wrap_seen = 1'b1;
        #1;
        check_all(tag);
    endtask

    // Assert reset at the current time and check the immediate clear.
    task automatic assert_reset(input string tag);
        reset = 1'b0;
        edges_seen = 0;
        wrap_seen  = 1'b0;
        #1;
        check_all(tag);
    endtask

    // Release reset while clk is low, well away from a rising edge.
    task automatic release_reset(input int offs);
        @(negedge clk);
        #(offs);
        reset = 1'b1;
    endtask

    // Watchdog: the bench is a fixed-length sequence on a free-running clock.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        #5;
        check_all("rst_hold");
        @(posedge clk);                 // t = 10, clk edge while in reset
        #1;
        check_all("rst_edge");
        #14;                            // t = 25, clk low
        reset = 1'b1;

        // ---------------- sequential count 1..10 ----------------
        for (int i = 0; i < 10; i++) step("seq");

        // ---------------- terminal count and wrap ----------------
        for (int i = 0; i < 5; i++) step("to_tc");     // reaches 15
        check_value("tc_at_15", 32'(cnt_if.tc), 32'd1);
        step("wrap16");
        check_value("q_at_16", 32'(cnt_if.Q), 32'd0);
        check_value("wrapped_16", 32'(cnt_if.wrapped), 32'd1);
        step("wrap17");
        check_value("wrapped_17", 32'(cnt_if.wrapped), 32'd1);

        // ---------------- divider: 64 edges ----------------
        for (int b = 0; b < WIDTH; b++) begin
            last_rise[b] = -1;
            prev_rise[b] = -1;
            high_time[b] = -1;
        end
        prev_q = cnt_if.Q;
        for (int i = 0; i < 64; i++) begin
            step("div");
            for (int b = 0; b < WIDTH; b++) begin
                if (!prev_q[b] && cnt_if.Q[b]) begin
                    prev_rise[b] = last_rise[b];
                    last_rise[b] = $time;
                end else if (prev_q[b] && !cnt_if.Q[b] && last_rise[b] >= 0) begin
                    high_time[b] = $time - last_rise[b];
                end
            end
            prev_q = cnt_if.Q;
        end
        for (int b = 0; b < WIDTH; b++) begin
            check_value($sformatf("period_q%0d", b),
                        32'(last_rise[b] - prev_rise[b]), 32'(40 << b));
            check_value($sformatf("high_q%0d", b),
                        32'(high_time[b]), 32'(20 << b));
        end

        // ---------------- async reset mid-count ----------------
        @(negedge clk);
        assert_reset("pre9_rst");
        release_reset(5);
        for (int i = 0; i < 9; i++) step("to9");
        @(posedge clk);
        edges_seen++;
        #5;                             // middle of clk-high phase
        check_value("q_before_rst", 32'(cnt_if.Q), 32'd10);
        assert_reset("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("rst_held");
        end
        release_reset(5);
        for (int i = 0; i < 3; i++) step("restart");

        // ---------------- ripple settling on falling edges ----------------
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges_seen++;
            if (edges_seen >= MODV) wrap_seen = 1'b1;
            @(negedge clk);
            check_all("fall");
        end

        // ---------------- randomized count / reset sequences ----------------
        for (int r = 0; r < 20; r++) begin
            int n_edges;
            int phase;
            int hold;
            n_edges = $urandom_range(1, 40);
            for (int i = 0; i < n_edges; i++) step("rnd");
            @(posedge clk);
            edges_seen++;
            if (edges_seen >= MODV) wrap_seen = 1'b1;
            phase = $urandom_range(2, 17);
            #(phase);
            check_all("rnd_pre");
            assert_reset("rnd_rst");
            hold = $urandom_range(0, 2);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check_all("rnd_hold");
            end
            release_reset($urandom_range(2, 8));
        end
        for (int i = 0; i < 20; i++) step("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_asynchronous_up_counter_4bit
